tdsp_rd_arb_mux: RTL and testbench
==================================

Name: tdsp_rd_arb_mux

Overview:
- Parametrised read-data arbiter/mux feeding the TDSP data input bus from NCH memory sources (scratch, data-sample, coefficient, I/O).
- Replaces the fixed two-way combinational select with:
  - registered request arbitration;
  - a fixed-latency read pipeline that tracks which source was granted;
  - a registered, valid-qualified output.
- Sits between the memory read ports and the TDSP core data input.

Parameters:
- DW, 16: data width.
- NCH, 4: number of read sources (2..8).
- IW, 2: source index width, must equal ceil(log2(NCH)).
- RD_LAT, 1: cycles from grant to source data valid (1..4).
- RR, 0: arbitration mode. 0 = fixed priority (lowest index wins). 1 = round-robin.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- rd_req, input, NCH: per-source read request. A level, held until granted.
- src_data, input, NCH*DW: source data. Channel i occupies bits [i*DW +: DW].
- t_stall, input, 1: core stall. No new grant is issued while high.
- rd_gnt, output, NCH: one-hot registered grant, pulses for 1 cycle.
- t_data, output, DW: registered TDSP data bus.
- t_valid, output, 1: t_data updated this cycle, 1-cycle pulse.
- t_src, output, IW: source index of the current t_data.
- conflict, output, 1: registered. High the cycle after >1 request was presented and one or more lost.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - rd_gnt=0, t_data=0, t_valid=0, t_src=0, conflict=0.
  - Round-robin pointer = 0.
  - All pipeline stage valids cleared.
- Arbitration (cycle N, t_stall=0, rd_req!=0):
  - Winner w is chosen and rd_gnt[w]=1 in cycle N+1.
  - Exactly one grant per cycle; back-to-back grants are allowed.
- RR=0: w = lowest set index of rd_req.
- RR=1: w = first set index at or above ptr, wrapping modulo NCH. ptr <= w+1 mod NCH on each grant. ptr is unchanged when there is no grant.
- A requester must drop rd_req in the cycle it sees rd_gnt, otherwise it is re-arbitrated. Any request still high in the cycle after its grant counts as a new request.
- t_stall=1: no grant is issued that cycle, ptr holds, and in-flight pipeline stages continue to advance.
- Read pipeline:
  - A grant pushes {valid=1, idx=w} into an RD_LAT-deep shift register.
  - When an entry exits the last stage, in that same cycle: t_data <= src_data[idx], t_src <= idx, t_valid <= 1.
- Total latency from rd_req sampled to t_valid is RD_LAT+1 cycles. Throughput is 1 word/cycle.
- When no entry exits, t_valid=0 and t_data/t_src hold their previous value. There is no default to any source.
- conflict: registered OR-reduction of "popcount(rd_req)>1 and a grant was issued" for each cycle.
- Reset mid-operation drops in-flight reads without producing t_valid. A source may re-request after reset.
- Widths: all indices are IW bits. src_data bits above NCH*DW do not exist, and unused index codes (NCH not a power of 2) are never granted.

Decomposition:
- Shared package/header (tdsp include):
  - DW default, to align with the TDSP word width;
  - the RR mode constants ARB_FIXED=0 and ARB_RR=1;
  - a one-hot-to-index helper function.
- One natural sub-module: tdsp_rr_arb (NCH requests, RR mode, ptr register, grant output), reusable by the write path.
- The read pipeline and output register stay in the top module.

Test Plan:
- Defaults (NCH=4, RR=0, RD_LAT=1):
  - Stimulus: rd_req=0001 for 1 cycle, src_data[0]=16'hA5A5 at the data-valid cycle.
  - Required: rd_gnt=0001 at cycle+1; t_valid=1, t_data=A5A5, t_src=0 at cycle+2; t_valid=0 afterwards with t_data held at A5A5.
- Fixed priority:
  - Stimulus: rd_req=1010 held, each requester dropping on grant.
  - Required: grant order 0010, then 1000; conflict=1 only on the first decision.
- Round-robin (RR=1):
  - Stimulus: rd_req=1111 held continuously.
  - Required: grants cycle 0001, 0010, 0100, 1000, 0001; t_src sequence 0,1,2,3,0 one cycle after each grant (RD_LAT=1).
- Stall:
  - Stimulus: t_stall=1 for 3 cycles with rd_req=0100 pending and one read in flight.
  - Required: the in-flight t_valid still appears; no rd_gnt during the stall; the grant appears 1 cycle after t_stall falls.
- RD_LAT=3:
  - Stimulus: back-to-back grants to channels 2 then 0.
  - Required: t_valid on consecutive cycles 4 cycles after the requests, with t_src=2 then 0 and data from the matching channel.
- Reset:
  - Stimulus: assert rst_n low asynchronously while 2 reads are in flight.
  - Required: all outputs go to 0 immediately; no t_valid after release; the first grant after release comes from ptr=0.

Source files
------------

// File: rtl/tdsp_rd_arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// tdsp_rd_arb_mux_pkg
// Shared definitions for the TDSP read-data arbiter/mux and its arbiter.
//   TDSP_DW        : TDSP data word width; the default for DW
//   ARB_FIXED      : arbitration mode, fixed priority (lowest index wins)
//   ARB_RR         : arbitration mode, round-robin
//   MAX_NCH        : largest source count the helpers support
//   onehot_to_idx  : convert a one-hot vector (up to MAX_NCH bits) to an index
// -----------------------------------------------------------------------------
package tdsp_rd_arb_mux_pkg;

    localparam int TDSP_DW   = 16;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MAX_NCH   = 8;

    // OR of the indices of all set bits. For a true one-hot input this is
    // exactly the index of the set bit, and it needs no priority chain.
    function automatic int onehot_to_idx(input logic [MAX_NCH-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_NCH; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tdsp_rr_arb.sv
// -----------------------------------------------------------------------------
// tdsp_rr_arb
// Registered NCH-way request arbiter, fixed-priority or round-robin.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req      : per-source request levels
//   en       : grant enable; no grant is issued while low
//   gnt      : one-hot registered grant, one cycle per decision
//   conflict : registered; high the cycle after a grant made while more
//              than one source was requesting
// -----------------------------------------------------------------------------
module tdsp_rr_arb
    import tdsp_rd_arb_mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 2,
    parameter int RR  = ARB_FIXED
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           en,
    output logic [NCH-1:0] gnt,
    output logic           conflict
);

    logic [IW-1:0]  ptr;
    logic [IW-1:0]  rot;
    logic [NCH-1:0] req_rot;
    logic           win_found;
    int             win_off;
    logic [IW-1:0]  win_idx;
    logic           issue;

    // Rotating the request vector so the search origin sits at bit 0 lets
    // both modes share one lowest-set-bit search; fixed priority simply
    // never rotates.
    assign rot     = (RR == ARB_RR) ? ptr : '0;
    assign req_rot = NCH'({req, req} >> rot);

    // Find the first requester at or after the search origin and map the
    // offset back to a real source index, wrapping modulo NCH.
    always_comb begin
        win_found = 1'b0;
        win_off   = 0;
        for (int j = 0; j < NCH; j++) begin
            if (!win_found && req_rot[j]) begin
                win_found = 1'b1;
                win_off   = j;
            end
        end
        win_idx = IW'((int'(rot) + win_off) % NCH);
    end

    assign issue = en && win_found;

    // Grant and conflict are registered so the decision shows up one cycle
    // after the requests were sampled. The pointer only moves on a grant,
    // so a stall or an idle cycle keeps the round-robin position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            conflict <= 1'b0;
            ptr      <= '0;
        end else begin
            gnt      <= issue ? (NCH'(1) << win_idx) : '0;
            conflict <= issue && ($countones(req) > 1);
            if (issue && (RR == ARB_RR)) begin
                ptr <= IW'((int'(win_idx) + 1) % NCH);
            end
        end
    end

endmodule

// File: rtl/tdsp_rd_arb_mux.sv
// -----------------------------------------------------------------------------
// tdsp_rd_arb_mux
// Read-data arbiter/mux feeding the TDSP data input bus from NCH memory
// sources. A registered arbiter grants one source per cycle, an RD_LAT-deep
// pipeline remembers which source was granted, and the word is captured into
// a registered, valid-qualified output when the pipeline entry retires.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rd_req    : per-source read request level, held until granted
//   src_data  : source data, channel i at [i*DW +: DW]
//   t_stall   : core stall; blocks new grants, in-flight reads continue
//   rd_gnt    : one-hot registered grant pulse
//   t_data    : registered TDSP data bus, holds when no read retires
//   t_valid   : one-cycle pulse when t_data was updated
//   t_src     : source index of the current t_data
//   conflict  : registered; a grant was made with more than one requester
// -----------------------------------------------------------------------------
module tdsp_rd_arb_mux
    import tdsp_rd_arb_mux_pkg::*;
#(
    parameter int DW     = TDSP_DW,
    parameter int NCH    = 4,
    parameter int IW     = 2,
    parameter int RD_LAT = 1,
    parameter int RR     = ARB_FIXED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    rd_req,
    input  logic [NCH*DW-1:0] src_data,
    input  logic              t_stall,
    output logic [NCH-1:0]    rd_gnt,
    output logic [DW-1:0]     t_data,
    output logic              t_valid,
    output logic [IW-1:0]     t_src,
    output logic              conflict
);

    logic           arb_en;
    logic           gnt_vld;
    logic [IW-1:0]  gnt_idx;
    logic           exit_vld;
    logic [IW-1:0]  exit_idx;
    logic [DW-1:0]  exit_data;

    assign arb_en = !t_stall;

    tdsp_rr_arb #(
        .NCH (NCH),
        .IW  (IW),
        .RR  (RR)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (rd_req),
        .en       (arb_en),
        .gnt      (rd_gnt),
        .conflict (conflict)
    );

    // The registered grant itself is the first pipeline stage: it is high in
    // the cycle after the decision, and carries the granted index.
    assign gnt_vld = |rd_gnt;
    assign gnt_idx = IW'(onehot_to_idx(MAX_NCH'(rd_gnt)));

    generate
        if (RD_LAT == 1) begin : g_no_pipe
            assign exit_vld = gnt_vld;
            assign exit_idx = gnt_idx;
        end else begin : g_pipe
            logic [RD_LAT-2:0] pipe_vld;
            logic [IW-1:0]     pipe_idx [RD_LAT-1];

            // Remaining RD_LAT-1 stages: a plain shift register that keeps
            // advancing during stalls so reads already granted still land.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_vld <= '0;
                    for (int i = 0; i < RD_LAT-1; i++) begin
                        pipe_idx[i] <= '0;
                    end
                end else begin
                    pipe_vld[0] <= gnt_vld;
                    pipe_idx[0] <= gnt_idx;
                    for (int i = 1; i < RD_LAT-1; i++) begin
                        pipe_vld[i] <= pipe_vld[i-1];
                        pipe_idx[i] <= pipe_idx[i-1];
                    end
                end
            end

            assign exit_vld = pipe_vld[RD_LAT-2];
            assign exit_idx = pipe_idx[RD_LAT-2];
        end
    endgenerate

    // Select the retiring source's word. Unused index codes never retire,
    // so the zero default is never captured.
    always_comb begin
        exit_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (exit_idx == IW'(i)) begin
                exit_data = src_data[i*DW +: DW];
            end
        end
    end

    // Output register: capture only when an entry retires; otherwise the bus
    // keeps its last word and t_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_data  <= '0;
            t_src   <= '0;
            t_valid <= 1'b0;
        end else begin
            t_valid <= exit_vld;
            if (exit_vld) begin
                t_data <= exit_data;
                t_src  <= exit_idx;
            end
        end
    end

endmodule

// File: tb/tb_tdsp_rd_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_tdsp_rd_arb_mux
// Two instances share one bench: instance 0 is fixed priority with RD_LAT=1,
// instance 1 is round-robin with RD_LAT=3. A reference model at each rising
// edge decides the expected grant and schedules the expected output word; a
// monitor on the falling edge compares grants, conflict and output words.
// -----------------------------------------------------------------------------
module tb_tdsp_rd_arb_mux;

    localparam int DW   = 16;
    localparam int NCH  = 4;
    localparam int IW   = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic run;

    logic [1:0][NCH-1:0]    req;
    logic [1:0]             stall;
    logic [1:0][NCH*DW-1:0] src;
    logic [1:0][NCH-1:0]    gnt;
    logic [1:0][DW-1:0]     tdat;
    logic [1:0]             tval;
    logic [1:0][IW-1:0]     tsrc;
    logic [1:0]             conf;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct { int idx; int due; } flight_t;
    typedef struct { logic [DW-1:0] data; int idx; } expect_t;

    flight_t infl0[$];
    flight_t infl1[$];
    expect_t sb0[$];
    expect_t sb1[$];

    int                  ptr [2];
    int                  edge_n = 0;
    logic [1:0][NCH-1:0] exp_gnt;
    logic [1:0]          exp_conf;
    logic [1:0][DW-1:0]  last_data;
    int                  last_src [2];

    always #5 clk = ~clk;

    tdsp_rd_arb_mux #(.DW(DW), .NCH(NCH), .IW(IW), .RD_LAT(LAT0), .RR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_req(req[0]), .src_data(src[0]),
        .t_stall(stall[0]), .rd_gnt(gnt[0]), .t_data(tdat[0]),
        .t_valid(tval[0]), .t_src(tsrc[0]), .conflict(conf[0])
    );

    tdsp_rd_arb_mux #(.DW(DW), .NCH(NCH), .IW(IW), .RD_LAT(LAT1), .RR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_req(req[1]), .src_data(src[1]),
        .t_stall(stall[1]), .rd_gnt(gnt[1]), .t_data(tdat[1]),
        .t_valid(tval[1]), .t_src(tsrc[1]), .conflict(conf[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // First requesting source at or after 'start', wrapping around.
    function automatic int pick(input logic [NCH-1:0] r, input int start);
        for (int n = 0; n < NCH; n++) begin
            if (r[(start + n) % NCH]) return (start + n) % NCH;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: at each rising edge retire reads that are due (the
    // word is whatever the source presents at that edge) and make the
    // arbitration decision from the sampled requests.
    always @(posedge clk) begin : model
        flight_t f;
        int      w;
        edge_n = edge_n + 1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                ptr[k]       = 0;
                exp_gnt[k]   = '0;
                exp_conf[k]  = 1'b0;
                last_data[k] = '0;
                last_src[k]  = 0;
                if (k == 0) begin infl0.delete(); sb0.delete(); end
                else        begin infl1.delete(); sb1.delete(); end
            end else begin
                if (k == 0) begin
                    while (infl0.size() > 0 && infl0[0].due == edge_n) begin
                        f = infl0.pop_front();
                        sb0.push_back('{src[0][f.idx*DW +: DW], f.idx});
                    end
                end else begin
                    while (infl1.size() > 0 && infl1[0].due == edge_n) begin
                        f = infl1.pop_front();
                        sb1.push_back('{src[1][f.idx*DW +: DW], f.idx});
                    end
                end
                exp_gnt[k]  = '0;
                exp_conf[k] = 1'b0;
                if (!stall[k] && req[k] != '0) begin
                    w = pick(req[k], (k == 1) ? ptr[k] : 0);
                    exp_gnt[k][w] = 1'b1;
                    exp_conf[k]   = ($countones(req[k]) > 1);
                    if (k == 1) ptr[k] = (w + 1) % NCH;
                    f.idx = w;
                    f.due = edge_n + lat_of(k);
                    if (k == 0) infl0.push_back(f);
                    else        infl1.push_back(f);
                end
            end
        end
    end

    // Monitor: compare everything the DUTs present, away from the clock edge.
    always @(negedge clk) begin : monitor
        expect_t e;
        logic    exp_v;
        if (run && rst_n) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("rd_gnt[%0d]", k), 64'(gnt[k]), 64'(exp_gnt[k]));
                checkOutput($sformatf("conflict[%0d]", k), 64'(conf[k]), 64'(exp_conf[k]));
                exp_v = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                checkOutput($sformatf("t_valid[%0d]", k), 64'(tval[k]), 64'(exp_v));
                if (exp_v) begin
                    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    last_data[k] = e.data;
                    last_src[k]  = e.idx;
                end
                checkOutput($sformatf("t_data[%0d]", k), 64'(tdat[k]), 64'(last_data[k]));
                checkOutput($sformatf("t_src[%0d]", k), 64'(tsrc[k]), 64'(last_src[k]));
            end
        end
    end

    // One negedge per cycle: drop granted requests, raise new ones, pick a
    // stall and fresh source data, all at the given percentages.
    task automatic applyStimulus(input int cycles, input int raise_pct, input int stall_pct,
                                 input bit drop, input bit rand_src);
        repeat (cycles) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (drop) req[k] = req[k] & ~gnt[k];
                for (int i = 0; i < NCH; i++) begin
                    if (!req[k][i] && ($urandom_range(99) < raise_pct)) req[k][i] = 1'b1;
                end
                stall[k] = ($urandom_range(99) < stall_pct);
                if (rand_src) src[k] = {$urandom, $urandom};
            end
        end
    endtask

    task automatic setReq(input logic [NCH-1:0] r);
        req[0] = r;
        req[1] = r;
    endtask

    task automatic checkAllZero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s rd_gnt[%0d]", tag, k), 64'(gnt[k]), 64'(0));
            checkOutput($sformatf("%s t_data[%0d]", tag, k), 64'(tdat[k]), 64'(0));
            checkOutput($sformatf("%s t_valid[%0d]", tag, k), 64'(tval[k]), 64'(0));
            checkOutput($sformatf("%s t_src[%0d]", tag, k), 64'(tsrc[k]), 64'(0));
            checkOutput($sformatf("%s conflict[%0d]", tag, k), 64'(conf[k]), 64'(0));
        end
    endtask

    initial begin
        run   = 1'b0;
        rst_n = 1'b0;
        req   = '0;
        stall = '0;
        src   = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        #1 rst_n = 1'b1;
        run = 1'b1;

        // Single read from channel 0, word held afterwards.
        @(negedge clk);
        setReq(4'b0001);
        src[0][15:0] = 16'hA5A5;
        src[1][15:0] = 16'h5A5A;
        applyStimulus(6, 0, 0, 1'b1, 1'b0);
        checkOutput("a5a5 held", 64'(tdat[0]), 64'(16'hA5A5));
        checkOutput("a5a5 valid low", 64'(tval[0]), 64'(0));

        // Two requesters, each dropping on grant.
        @(negedge clk);
        setReq(4'b1010);
        applyStimulus(6, 0, 0, 1'b1, 1'b1);

        // All four held continuously.
        @(negedge clk);
        setReq(4'b1111);
        applyStimulus(9, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        setReq(4'b0000);
        applyStimulus(5, 0, 0, 1'b1, 1'b1);

        // Read in flight, then a pending request held off by a 3-cycle stall.
        @(negedge clk);
        setReq(4'b0001);
        @(negedge clk);
        setReq(4'b0100);
        stall = 2'b11;
        repeat (2) @(negedge clk);
        @(negedge clk);
        stall = 2'b00;
        applyStimulus(6, 0, 0, 1'b1, 1'b1);

        // Back-to-back grants to channel 2 then channel 0.
        @(negedge clk);
        setReq(4'b0100);
        @(negedge clk);
        setReq(4'b0001);
        @(negedge clk);
        setReq(4'b0000);
        applyStimulus(6, 0, 0, 1'b1, 1'b1);

        // Randomised traffic with stalls.
        applyStimulus(3000, 30, 15, 1'b1, 1'b1);
        @(negedge clk);
        setReq(4'b0000);
        stall = 2'b00;
        applyStimulus(6, 0, 0, 1'b1, 1'b1);

        // Reset with two reads in flight on the RD_LAT=3 instance.
        @(negedge clk);
        setReq(4'b0001);
        @(negedge clk);
        setReq(4'b0010);
        @(negedge clk);
        setReq(4'b0000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkAllZero("async reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(6, 0, 0, 1'b1, 1'b1);

        // First round-robin grant after reset starts from pointer 0.
        @(negedge clk);
        setReq(4'b1010);
        @(negedge clk);
        checkOutput("rr first grant after reset", 64'(gnt[1]), 64'(4'b0010));
        req[0] = req[0] & ~gnt[0];
        req[1] = req[1] & ~gnt[1];
        applyStimulus(6, 0, 0, 1'b1, 1'b1);

        @(negedge clk);
        setReq(4'b0000);
        applyStimulus(8, 0, 0, 1'b1, 1'b1);
        checkOutput("leftover expected words[0]", 64'(sb0.size() + infl0.size()), 64'(0));
        checkOutput("leftover expected words[1]", 64'(sb1.size() + infl1.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
